// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet front end: default frame geometry and the
// image loader state encoding.
package lenet_pkg;

    localparam int BITWIDTH_DEF = 32;
    localparam int IMG_DIM_DEF  = 28;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } loader_state_e;

    // A 1-pixel frame still needs a 1-bit counter to hold the (0,1) load value.
    function automatic int cnt_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major raster position counter: col wraps DIM-1 -> 0 and bumps row;
// clear returns to (0,0), load jumps to (0,1) right after a frame-start pixel.
module raster_counter
    import lenet_pkg::*;
#(
    parameter int  DIM = IMG_DIM_DEF,
    localparam int CW  = cnt_width(DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic          advance,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col
);

    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            row <= '0;
            col <= CW'(1);
        end else if (advance) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/image_loader.sv
// Collects a raster-ordered pixel stream into a full IMG_DIM x IMG_DIM frame and
// holds it for the accelerator until acknowledged. Define IMAGE_LOADER_ERRCNT_EN
// to build the saturating protocol-error counter; otherwise err_count is tied to 0.
module image_loader
    import lenet_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int IMG_DIM  = IMG_DIM_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [BITWIDTH-1:0] pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    output logic                       pix_ready,
    output logic signed [BITWIDTH-1:0] image [IMG_DIM-1:0][IMG_DIM-1:0],
    output logic                       frame_valid,
    input  logic                       frame_ack,
    output logic [15:0]                err_count
);

    localparam int            CW   = cnt_width(IMG_DIM);
    localparam logic [CW-1:0] LAST = CW'(IMG_DIM - 1);

    loader_state_e state_q, state_d;

    logic [CW-1:0] row, col;
    logic [CW-1:0] wr_row, wr_col;
    logic          xfer, frame_done;
    logic          wr_en, cnt_clear, cnt_load, cnt_adv, err_evt;

    assign xfer = pix_valid & pix_ready;

    // A frame-start pixel always lands at (0,0), whatever the counter says.
    assign wr_row     = pix_sof ? '0 : row;
    assign wr_col     = pix_sof ? '0 : col;
    assign frame_done = (wr_row == LAST) && (wr_col == LAST);

    raster_counter #(
        .DIM (IMG_DIM)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .load    (cnt_load),
        .advance (cnt_adv),
        .row     (row),
        .col     (col)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        wr_en     = 1'b0;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_adv   = 1'b0;
        err_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (pix_sof) begin
                        wr_en    = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = frame_done ? HOLD : FILL;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            FILL: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        cnt_load = 1'b1;
                        err_evt  = 1'b1;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                    if (frame_done) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // pix_ready is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            pix_ready   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_ready   <= (state_d != HOLD);
            frame_valid <= (state_d == HOLD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the frame buffer is built from resettable flops, so rst clears every word at once.
        if (rst) begin
            for (int r = 0; r < IMG_DIM; r++) begin
                for (int c = 0; c < IMG_DIM; c++) begin
                    image[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            image[wr_row][wr_col] <= pix_in;
        end
    end

`ifdef IMAGE_LOADER_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_evt && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
    assign err_count      = '0;
`endif

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, pixel word width (signed).
REQ-002 The block SHALL have parameter IMG_DIM, default 28, frame edge length in pixels.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port pix_in, input, BITWIDTH signed, streamed pixel, raster order (row-major).
REQ-006 The block SHALL have port pix_valid, input, 1, pix_in valid.
REQ-007 The block SHALL have port pix_sof, input, 1, qualifies pixel as frame start (0,0).
REQ-008 The block SHALL have port pix_ready, output, 1, block accepts pixel this cycle.
REQ-009 The block SHALL have port image, output, signed [BITWIDTH-1:0] [IMG_DIM-1:0][IMG_DIM-1:0], frame feeding the accelerator image input.
REQ-010 The block SHALL have port frame_valid, output, 1, image holds a complete frame.
REQ-011 The block SHALL have port frame_ack, input, 1, consumer releases the frame.
REQ-012 The block SHALL have port err_count, output, 16, saturating error counter (see Configuration).

Function
REQ-013 Transfer SHALL occur on a rising edge where pix_valid and pix_ready are both 1.
REQ-014 FSM states SHALL be IDLE, FILL, HOLD; pix_ready = 1 in IDLE and FILL, 0 in HOLD.
REQ-015 IDLE: a transfer with pix_sof=1 SHALL write image[0][0], set col=1,row=0, go to FILL; a transfer with pix_sof=0 SHALL be discarded and count as one error.
REQ-016 FILL: each transfer SHALL write image[row][col]; col SHALL wrap IMG_DIM-1 -> 0 with row incremented.
REQ-017 FILL: a transfer with pix_sof=1 SHALL resynchronise: write image[0][0], set col=1,row=0, count one error; stale pixels are not cleared.
REQ-018 The transfer writing image[IMG_DIM-1][IMG_DIM-1] SHALL move FSM to HOLD; frame_valid SHALL be 1 from the following cycle (one-cycle latency).
REQ-019 HOLD: image SHALL remain stable; pix_valid ignored without error.
REQ-020 HOLD with frame_ack=1 SHALL clear frame_valid and return to IDLE on that edge; frame_ack outside HOLD SHALL be ignored.
REQ-021 A 1x1 frame (IMG_DIM=1) SHALL go IDLE -> HOLD on the single sof transfer.
REQ-022 Row/col counters SHALL be $clog2(IMG_DIM) bits, unsigned; pixels are stored unmodified.

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE, row=col=0, frame_valid=0, pix_ready=0, err_count=0, all image words 0.
REQ-024 rst mid-FILL or mid-HOLD SHALL abandon the frame; after deassertion pix_ready SHALL rise on the first clock edge.

Configuration
REQ-025 Macro IMAGE_LOADER_ERRCNT_EN defined: err_count SHALL increment by 1 per error event (REQ-015, REQ-017), saturating at 16'hFFFF.
REQ-026 Macro undefined: err_count SHALL be constant 0 and no counter logic synthesised; all other behaviour identical.

Structure
REQ-027 Package lenet_pkg SHALL hold BITWIDTH, IMG_DIM defaults and the loader state enum (IDLE, FILL, HOLD).
REQ-028 One sub-module raster_counter SHALL implement row/col counting with wrap, clear and load-(0,1) controls.

Verification
REQ-029 Reset then 784 transfers, first with sof, pixel value = row*28+col -> frame_valid=1 one cycle after last, image[27][27]=783, pix_ready=0, err_count=0.
REQ-030 5 non-sof pixels in IDLE, then full frame -> frame completes normally, err_count=5 (0 without macro).
REQ-031 sof at transfer 100 of FILL, then 784 more -> frame completes after 884 total, err_count=1, image[0][0]=value sent with second sof.
REQ-032 HOLD with pix_valid=1 for 10 cycles, then frame_ack -> image unchanged, frame_valid 0 next cycle, pix_ready 1.
REQ-033 rst asserted at transfer 400 between edges -> outputs zero immediately, image all 0; next sof frame loads correctly.
REQ-034 pix_valid toggled randomly 50% during FILL -> exactly 784 transfers fill the frame, no duplicated or skipped positions.
